counter_access_arbiter: RTL and testbench
=========================================

// Module: counter_access_arbiter
// PURPOSE
//  Control/arbitration front-end for the user-area count register.
//  Shares the counter's load port between two requesters, the Wishbone slave (via a 4-word CSR window) and the
//  logic-analyzer load probe. Also drives count-enable, a compare-match IRQ and readback.
//  Sits between the wishbone/LA ports of the user project and a plain loadable counter.
// PARAMETERS
//  BITS       32             counter / compare / LA data width (1..32)
//  ADDR_BASE  32'h3000_0000  CSR window base; decode on wbs_adr_i[31:4]==ADDR_BASE[31:4]
// PORTS
//  wb_clk_i        in   1     single clock for all state
//  wb_rst_n_i      in   1     asynchronous active-low reset
//  wbs_cyc_i       in   1     wishbone cycle
//  wbs_stb_i       in   1     wishbone strobe
//  wbs_we_i        in   1     wishbone write
//  wbs_sel_i       in   4     byte enables
//  wbs_adr_i       in   32    byte address; word select = adr[3:2]
//  wbs_dat_i       in   32    write data
//  wbs_ack_o       out  1     one-cycle acknowledge
//  wbs_dat_o       out  32    read data; valid when ack=1, else 0
//  la_req_i        in   1     LA load request (level, held until granted)
//  la_data_i       in   BITS  LA load value
//  la_gnt_o        out  1     one-cycle grant to LA; load happens this cycle
//  cnt_value_i     in   BITS  current counter value
//  cnt_en_o        out  1     counter increment enable (= CTRL.en)
//  cnt_load_o      out  1     one-cycle load strobe to counter
//  cnt_load_val_o  out  BITS  load value, valid when cnt_load_o=1
//  irq_o           out  1     registered interrupt = STATUS.match & CTRL.irq_en
// BEHAVIOUR
//  Reset: every output 0; CTRL, COMPARE, STATUS, FSM=IDLE, last_gnt=LA. wbs_ack_o drops immediately on reset,
//   even mid-transaction; a pending LA request is regranted after reset release.
//  CSR map (adr[3:2]): 0 CTRL {irq_en[2],la_prio[1],en[0]} RW; 1 COUNT R=cnt_value_i, W=load request;
//   2 COMPARE RW; 3 STATUS {la_pend[1] RO = la_req_i&~la_gnt_o, match[0] W1C}. Unused bits read 0.
//  Byte enables apply to all writable CSRs; a COUNT write loads {sel ? wbs_dat_i byte : cnt_value_i byte}.
//  Out-of-window access: no ack, no side effect (bus times out upstream).
//  FSM: IDLE, WAIT, ACK.
//   IDLE: cyc&stb&hit -> non-COUNT-write: ACK next cycle (side effect applied on that edge).
//         COUNT write: won arbitration -> ACK; lost -> WAIT.
//   WAIT: hold until COUNT write wins -> ACK. cyc or stb dropped -> IDLE, no load.
//   ACK:  wbs_ack_o=1 exactly one cycle -> IDLE. A new request is not sampled in the ACK cycle.
//  Latency: CSR access ack 1 cycle after stb sampled in IDLE; WAIT adds 1 cycle per lost arbitration.
//  Arbitration runs only when a COUNT write and la_req_i both request in the same cycle:
//   la_prio=1: LA always wins.
//   la_prio=0: round-robin; winner = source != last_gnt. last_gnt updates on every grant.
//   Lone requester wins immediately. One load per cycle max.
//  Load: LA grant -> la_gnt_o=1, cnt_load_o=1, cnt_load_val_o=la_data_i (registered) in the next cycle.
//   WB COUNT load is asserted in the ACK cycle. Both occur in the cycle after the grant decision.
//   la_req_i held high gets a grant every cycle unless WB contends.
//  Match: cnt_en_o & (cnt_value_i==COMPARE) sets STATUS.match.
//   A simultaneous W1C and set in the same cycle leaves match=1 (set wins). irq_o lags match by one cycle.
//  Widths: BITS<32 -> upper CSR bits read 0 and ignore writes.
//   Counter wrap-around is the counter's concern; compare at value 0 after wrap still matches.
// TESTING
//  1 Reset, write CTRL=0x1 -> ack 1 cycle after stb, cnt_en_o=1, read CTRL=0x1, other outputs 0.
//  2 WB write COUNT=0x0000_00AA sel=4'b0001 with cnt_value_i=0x1234_5600
//    -> cnt_load_o pulse with 0x1234_56AA in the ack cycle.
//  3 la_req_i=1 and WB COUNT write (0x55) in the same cycle, la_prio=0, last_gnt=LA -> WB loads first (ack);
//    next cycle la_gnt_o/load la_data_i. Repeat with la_prio=1 -> LA first, WB in WAIT one cycle, then ack.
//  4 COMPARE=0x10, irq_en=1, en=1, cnt_value_i ramps 0x0E..0x11 -> match set at 0x10, irq_o next cycle;
//    W1C STATUS=0x1 clears both; simultaneous W1C and match keeps 1.
//  5 Deassert wb_rst_n_i during WAIT and during ACK -> ack/load/gnt low immediately, CSRs 0;
//    after release held la_req_i is granted once.
//  6 Access at ADDR_BASE+0x10 -> no ack within 16 cycles, no CSR change.

Source files
------------

// File: rtl/counter_access_arbiter_if.sv
// Wishbone slave bus bundle for the counter access arbiter CSR window.
// The master modport drives requests; the slave modport returns ack and read data.
interface counter_access_arbiter_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/counter_access_arbiter.sv
// Front-end for a loadable counter: shares its load port between a Wishbone CSR window
// and a logic-analyzer load probe, and provides count-enable, compare-match IRQ and readback.
module counter_access_arbiter #(
  parameter int          BITS      = 32,
  parameter logic [31:0] ADDR_BASE = 32'h3000_0000
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_n_i,
  counter_access_arbiter_if.slave wb,
  input  logic                    la_req_i,
  input  logic [BITS-1:0]         la_data_i,
  output logic                    la_gnt_o,
  input  logic [BITS-1:0]         cnt_value_i,
  output logic                    cnt_en_o,
  output logic                    cnt_load_o,
  output logic [BITS-1:0]         cnt_load_val_o,
  output logic                    irq_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK
  } state_t;

  localparam logic [1:0] W_CTRL    = 2'd0;
  localparam logic [1:0] W_COUNT   = 2'd1;
  localparam logic [1:0] W_COMPARE = 2'd2;
  localparam logic [1:0] W_STATUS  = 2'd3;
  localparam logic       GNT_LA    = 1'b0;
  localparam logic       GNT_WB    = 1'b1;

  state_t          state_q, state_d;
  logic [2:0]      ctrl_q, ctrl_d;
  logic [BITS-1:0] compare_q, compare_d;
  logic            match_q, match_d;
  logic            irq_q, irq_d;
  logic            last_gnt_q, last_gnt_d;
  logic            la_gnt_q, la_gnt_d;
  logic            load_q, load_d;
  logic [BITS-1:0] load_val_q, load_val_d;
  logic [31:0]     rdata_q, rdata_d;

  logic            hit, count_wr, wb_cnt_req, la_wins, wb_grant, la_grant;
  logic            csr_access, csr_write, la_pend, match_hit, w1c_match;
  logic [1:0]      word;
  logic [31:0]     compare_word, cnt_word, merged_cmp, merged_cnt, read_word;
  logic            unused_adr;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = sel[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return res;
  endfunction

  assign unused_adr = ^wb.wbs_adr_i[1:0];

  assign hit        = wb.wbs_cyc_i & wb.wbs_stb_i & (wb.wbs_adr_i[31:4] == ADDR_BASE[31:4]);
  assign word       = wb.wbs_adr_i[3:2];
  assign count_wr   = hit & wb.wbs_we_i & (word == W_COUNT);
  assign wb_cnt_req = count_wr & ((state_q == ST_IDLE) | (state_q == ST_WAIT));

  // Contention only exists when both a COUNT write and the LA probe want the load port.
  assign la_wins    = wb_cnt_req & la_req_i & (ctrl_q[1] | (last_gnt_q == GNT_WB));
  assign wb_grant   = wb_cnt_req & ~la_wins;
  assign la_grant   = la_req_i & ~wb_grant;

  assign csr_access = (state_q == ST_IDLE) & hit & ~count_wr;
  assign csr_write  = csr_access & wb.wbs_we_i;
  assign la_pend    = la_req_i & ~la_gnt_q;
  assign match_hit  = ctrl_q[0] & (cnt_value_i == compare_q);
  assign w1c_match  = csr_write & (word == W_STATUS) & wb.wbs_sel_i[0] & wb.wbs_dat_i[0];

  always_comb begin
    compare_word                 = '0;
    compare_word[BITS-1:0]       = compare_q;
    cnt_word                     = '0;
    cnt_word[BITS-1:0]           = cnt_value_i;
    merged_cmp = merge_bytes(compare_word, wb.wbs_dat_i, wb.wbs_sel_i);
    merged_cnt = merge_bytes(cnt_word, wb.wbs_dat_i, wb.wbs_sel_i);
    case (word)
      W_CTRL:    read_word = {29'd0, ctrl_q};
      W_COUNT:   read_word = cnt_word;
      W_COMPARE: read_word = compare_word;
      default:   read_word = {30'd0, la_pend, match_q};
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (hit) begin
          if (count_wr && !wb_grant) state_d = ST_WAIT;
          else                       state_d = ST_ACK;
        end
      end
      ST_WAIT: begin
        if (!count_wr)     state_d = ST_IDLE;
        else if (wb_grant) state_d = ST_ACK;
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // CSR side effects land on the same edge that moves the FSM into ACK.
  always_comb begin
    ctrl_d    = ctrl_q;
    compare_d = compare_q;
    rdata_d   = '0;
    if (csr_write && word == W_CTRL && wb.wbs_sel_i[0]) ctrl_d = wb.wbs_dat_i[2:0];
    if (csr_write && word == W_COMPARE)                 compare_d = merged_cmp[BITS-1:0];
    if (csr_access && !wb.wbs_we_i)                     rdata_d = read_word;
    match_d = match_q;
    if (w1c_match) match_d = 1'b0;
    if (match_hit) match_d = 1'b1;
    irq_d = match_q & ctrl_q[2];
  end

  always_comb begin
    la_gnt_d   = la_grant;
    load_d     = wb_grant | la_grant;
    load_val_d = '0;
    last_gnt_d = last_gnt_q;
    if (wb_grant) begin
      load_val_d = merged_cnt[BITS-1:0];
      last_gnt_d = GNT_WB;
    end else if (la_grant) begin
      load_val_d = la_data_i;
      last_gnt_d = GNT_LA;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q    <= ST_IDLE;
      ctrl_q     <= '0;
      compare_q  <= '0;
      match_q    <= 1'b0;
      irq_q      <= 1'b0;
      last_gnt_q <= GNT_LA;
      la_gnt_q   <= 1'b0;
      load_q     <= 1'b0;
      load_val_q <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      compare_q  <= compare_d;
      match_q    <= match_d;
      irq_q      <= irq_d;
      last_gnt_q <= last_gnt_d;
      la_gnt_q   <= la_gnt_d;
      load_q     <= load_d;
      load_val_q <= load_val_d;
      rdata_q    <= rdata_d;
    end
  end

  assign wb.wbs_ack_o   = (state_q == ST_ACK);
  assign wb.wbs_dat_o   = rdata_q;
  assign la_gnt_o       = la_gnt_q;
  assign cnt_en_o       = ctrl_q[0];
  assign cnt_load_o     = load_q;
  assign cnt_load_val_o = load_val_q;
  assign irq_o          = irq_q;

  a_ack_single: assert property (@(posedge wb_clk_i) disable iff (!wb_rst_n_i)
    wb.wbs_ack_o |=> !wb.wbs_ack_o);
  a_gnt_loads: assert property (@(posedge wb_clk_i) disable iff (!wb_rst_n_i)
    la_gnt_o |-> cnt_load_o);

endmodule

// File: tb/tb_counter_access_arbiter.sv
// Directed bench for counter_access_arbiter: a CSR vector table plus hand-written
// sequences for arbitration, match/IRQ, reset mid-transaction and out-of-window access.
module tb_counter_access_arbiter;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        la_req;
  logic [31:0] la_data;
  logic        la_gnt;
  logic [31:0] cnt_value;
  logic        cnt_en;
  logic        cnt_load;
  logic [31:0] cnt_load_val;
  logic        irq;
  int          n_checks = 0;
  int          n_errors = 0;

  counter_access_arbiter_if bus();

  counter_access_arbiter #(.BITS(32), .ADDR_BASE(BASE)) dut (
    .wb_clk_i       (clk),
    .wb_rst_n_i     (rst_n),
    .wb             (bus),
    .la_req_i       (la_req),
    .la_data_i      (la_data),
    .la_gnt_o       (la_gnt),
    .cnt_value_i    (cnt_value),
    .cnt_en_o       (cnt_en),
    .cnt_load_o     (cnt_load),
    .cnt_load_val_o (cnt_load_val),
    .irq_o          (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  word;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [31:0] cnt;
    logic [31:0] exp_rd;
    logic        exp_load;
    logic [31:0] exp_lval;
    logic        exp_en;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  // One bus transaction, bounded by max_cyc; lat stays 0 when no ack arrives.
  task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                         input logic [31:0] dat, input int max_cyc,
                         output int lat, output logic [31:0] rdata,
                         output logic load, output logic [31:0] lval);
    lat = 0; rdata = '0; load = 1'b0; lval = '0;
    bus.wbs_adr_i = adr; bus.wbs_we_i = we; bus.wbs_sel_i = sel; bus.wbs_dat_i = dat;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1;
    for (int c = 1; c <= max_cyc; c++) begin
      @(posedge clk); #1;
      if (bus.wbs_ack_o) begin
        lat = c; rdata = bus.wbs_dat_o; load = cnt_load; lval = cnt_load_val;
        break;
      end
    end
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic csr_write(input logic [1:0] word, input logic [3:0] sel, input logic [31:0] dat, input string name);
    int lat; logic [31:0] rd; logic ld; logic [31:0] lv;
    wb_xfer(BASE | {28'd0, word, 2'b00}, 1'b1, sel, dat, 8, lat, rd, ld, lv);
    check_output({name, " latency"}, lat, 1);
  endtask

  task automatic csr_read(input logic [1:0] word, input logic [31:0] exp, input string name);
    int lat; logic [31:0] rd; logic ld; logic [31:0] lv;
    wb_xfer(BASE | {28'd0, word, 2'b00}, 1'b0, 4'hF, 32'h0, 8, lat, rd, ld, lv);
    check_output({name, " latency"}, lat, 1);
    check_output(name, rd, exp);
  endtask

  task automatic start_count_write(input logic [31:0] dat);
    bus.wbs_adr_i = BASE | 32'h4; bus.wbs_we_i = 1'b1; bus.wbs_sel_i = 4'hF;
    bus.wbs_dat_i = dat; bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1;
  endtask

  task automatic drop_bus();
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          lat;
    logic [31:0] rd, lv;
    logic        ld;

    vecs[0]  = '{1'b1, 2'd0, 4'hF, 32'h0000_0001, 32'h1234_5600, 32'h0,          1'b0, 32'h0,          1'b1};
    vecs[1]  = '{1'b0, 2'd0, 4'hF, 32'h0,          32'h1234_5600, 32'h0000_0001, 1'b0, 32'h0,          1'b1};
    vecs[2]  = '{1'b1, 2'd1, 4'h1, 32'h0000_00AA, 32'h1234_5600, 32'h0,          1'b1, 32'h1234_56AA, 1'b1};
    vecs[3]  = '{1'b1, 2'd1, 4'hA, 32'hDEAD_BEEF, 32'h1234_5600, 32'h0,          1'b1, 32'hDE34_BE00, 1'b1};
    vecs[4]  = '{1'b0, 2'd1, 4'hF, 32'h0,          32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 32'h0,          1'b1};
    vecs[5]  = '{1'b1, 2'd2, 4'hF, 32'h1122_3344, 32'h1234_5600, 32'h0,          1'b0, 32'h0,          1'b1};
    vecs[6]  = '{1'b1, 2'd2, 4'h4, 32'hAABB_CCDD, 32'h1234_5600, 32'h0,          1'b0, 32'h0,          1'b1};
    vecs[7]  = '{1'b0, 2'd2, 4'hF, 32'h0,          32'h1234_5600, 32'h11BB_3344, 1'b0, 32'h0,          1'b1};
    vecs[8]  = '{1'b1, 2'd0, 4'hE, 32'hFFFF_FFFF, 32'h1234_5600, 32'h0,          1'b0, 32'h0,          1'b1};
    vecs[9]  = '{1'b0, 2'd0, 4'hF, 32'h0,          32'h1234_5600, 32'h0000_0001, 1'b0, 32'h0,          1'b1};
    vecs[10] = '{1'b1, 2'd0, 4'h1, 32'hFFFF_FFF8, 32'h1234_5600, 32'h0,          1'b0, 32'h0,          1'b0};
    vecs[11] = '{1'b0, 2'd0, 4'hF, 32'h0,          32'h1234_5600, 32'h0,          1'b0, 32'h0,          1'b0};
    vecs[12] = '{1'b1, 2'd0, 4'h1, 32'h0000_0005, 32'h1234_5600, 32'h0,          1'b0, 32'h0,          1'b1};
    vecs[13] = '{1'b0, 2'd3, 4'hF, 32'h0,          32'h1234_5600, 32'h0,          1'b0, 32'h0,          1'b1};

    rst_n = 1'b0; la_req = 1'b0; la_data = '0; cnt_value = '0;
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = '0; bus.wbs_adr_i = '0; bus.wbs_dat_i = '0;

    // Reset values
    #12;
    check_bit("reset ack", bus.wbs_ack_o, 1'b0);
    check_output("reset dat_o", bus.wbs_dat_o, 32'h0);
    check_bit("reset la_gnt", la_gnt, 1'b0);
    check_bit("reset cnt_en", cnt_en, 1'b0);
    check_bit("reset cnt_load", cnt_load, 1'b0);
    check_output("reset load_val", cnt_load_val, 32'h0);
    check_bit("reset irq", irq, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // CSR vector table
    for (int i = 0; i < NV; i++) begin
      cnt_value = vecs[i].cnt;
      wb_xfer(BASE | {28'd0, vecs[i].word, 2'b00}, vecs[i].we, vecs[i].sel, vecs[i].dat, 8, lat, rd, ld, lv);
      check_output($sformatf("vec%0d latency", i), lat, 1);
      check_output($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
      check_bit($sformatf("vec%0d load", i), ld, vecs[i].exp_load);
      if (vecs[i].exp_load) check_output($sformatf("vec%0d load_val", i), lv, vecs[i].exp_lval);
      check_bit($sformatf("vec%0d cnt_en", i), cnt_en, vecs[i].exp_en);
    end
    check_bit("load pulse ended", cnt_load, 1'b0);
    check_output("dat_o idle", bus.wbs_dat_o, 32'h0);
    check_bit("ack idle", bus.wbs_ack_o, 1'b0);

    // Lone LA request, leaves last grant = LA
    csr_write(2'd0, 4'h1, 32'h0, "ctrl clear");
    la_req = 1'b1; la_data = 32'h77;
    @(posedge clk); #1;
    la_req = 1'b0;
    check_bit("lone la_gnt", la_gnt, 1'b1);
    check_bit("lone la load", cnt_load, 1'b1);
    check_output("lone la load_val", cnt_load_val, 32'h77);
    @(posedge clk); #1;
    check_bit("lone la_gnt drop", la_gnt, 1'b0);

    // Round-robin contention: WB wins, LA follows
    cnt_value = 32'h0; la_req = 1'b1; la_data = 32'h99;
    start_count_write(32'h55);
    @(posedge clk); #1;
    check_bit("rr wb ack", bus.wbs_ack_o, 1'b1);
    check_bit("rr wb load", cnt_load, 1'b1);
    check_output("rr wb load_val", cnt_load_val, 32'h55);
    check_bit("rr la waits", la_gnt, 1'b0);
    drop_bus();
    @(posedge clk); #1;
    la_req = 1'b0;
    check_bit("rr ack single", bus.wbs_ack_o, 1'b0);
    check_bit("rr la_gnt", la_gnt, 1'b1);
    check_output("rr la load_val", cnt_load_val, 32'h99);
    @(posedge clk); #1;

    // Priority contention: LA wins, WB waits one cycle
    csr_write(2'd0, 4'h1, 32'h2, "ctrl prio");
    la_req = 1'b1; la_data = 32'h42;
    start_count_write(32'h66);
    @(posedge clk); #1;
    la_req = 1'b0;
    check_bit("prio la_gnt", la_gnt, 1'b1);
    check_output("prio la load_val", cnt_load_val, 32'h42);
    check_bit("prio wb waits", bus.wbs_ack_o, 1'b0);
    @(posedge clk); #1;
    check_bit("prio wb ack", bus.wbs_ack_o, 1'b1);
    check_bit("prio wb load", cnt_load, 1'b1);
    check_output("prio wb load_val", cnt_load_val, 32'h66);
    check_bit("prio la_gnt drop", la_gnt, 1'b0);
    drop_bus();
    @(posedge clk); #1;
    check_bit("prio load end", cnt_load, 1'b0);

    // Compare match and IRQ
    cnt_value = 32'h0E;
    csr_write(2'd2, 4'hF, 32'h10, "compare set");
    csr_write(2'd0, 4'h1, 32'h5, "ctrl irq en");
    cnt_value = 32'h0F;
    @(posedge clk); #1;
    check_bit("irq before match", irq, 1'b0);
    cnt_value = 32'h10;
    @(posedge clk); #1;
    check_bit("irq lags match", irq, 1'b0);
    cnt_value = 32'h11;
    @(posedge clk); #1;
    check_bit("irq after match", irq, 1'b1);
    csr_read(2'd3, 32'h1, "status match");
    csr_write(2'd3, 4'h1, 32'h1, "status w1c");
    check_bit("irq cleared", irq, 1'b0);
    csr_read(2'd3, 32'h0, "status cleared");
    cnt_value = 32'h10;
    bus.wbs_adr_i = BASE | 32'hC; bus.wbs_we_i = 1'b1; bus.wbs_sel_i = 4'h1;
    bus.wbs_dat_i = 32'h1; bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1;
    @(posedge clk); #1;
    check_bit("w1c race ack", bus.wbs_ack_o, 1'b1);
    cnt_value = 32'h11;
    drop_bus();
    @(posedge clk); #1;
    check_bit("w1c race irq", irq, 1'b1);
    csr_read(2'd3, 32'h1, "status set wins");
    csr_write(2'd3, 4'h1, 32'h1, "status w1c again");
    csr_write(2'd0, 4'h1, 32'h2, "ctrl prio only");

    // Reset while WB sits in WAIT; held LA request regranted afterwards
    la_req = 1'b1; la_data = 32'h31;
    start_count_write(32'h77);
    @(posedge clk); #1;
    check_bit("wait la_gnt", la_gnt, 1'b1);
    @(posedge clk); #1;
    check_bit("wait no ack", bus.wbs_ack_o, 1'b0);
    #2; rst_n = 1'b0; drop_bus();
    #1;
    check_bit("rst wait ack", bus.wbs_ack_o, 1'b0);
    check_bit("rst wait la_gnt", la_gnt, 1'b0);
    check_bit("rst wait load", cnt_load, 1'b0);
    check_output("rst wait load_val", cnt_load_val, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    la_req = 1'b0;
    check_bit("post rst la_gnt", la_gnt, 1'b1);
    check_output("post rst load_val", cnt_load_val, 32'h31);
    @(posedge clk); #1;
    check_bit("post rst la_gnt once", la_gnt, 1'b0);
    csr_read(2'd0, 32'h0, "post rst ctrl");
    csr_read(2'd2, 32'h0, "post rst compare");

    // Reset during the ACK cycle
    bus.wbs_adr_i = BASE; bus.wbs_we_i = 1'b1; bus.wbs_sel_i = 4'hF;
    bus.wbs_dat_i = 32'h1; bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1;
    @(posedge clk); #1;
    check_bit("ack before rst", bus.wbs_ack_o, 1'b1);
    check_bit("en before rst", cnt_en, 1'b1);
    #2; rst_n = 1'b0; drop_bus();
    #1;
    check_bit("rst ack drop", bus.wbs_ack_o, 1'b0);
    check_bit("rst en drop", cnt_en, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    csr_read(2'd0, 32'h0, "post ack rst ctrl");

    // Out-of-window access
    wb_xfer(BASE + 32'h10, 1'b1, 4'hF, 32'h7, 16, lat, rd, ld, lv);
    check_output("oow no ack", lat, 0);
    check_bit("oow no load", cnt_load, 1'b0);
    csr_read(2'd0, 32'h0, "oow ctrl unchanged");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
